fence_sequencer: RTL and testbench
==================================

# fence_sequencer

Sequences the multi-cycle fence-class operations retired by the commit stage: FENCE, FENCE.I, SFENCE.VMA and externally requested D$ flushes. It accepts one request at a time from commit and holds off further requests while busy. It then waits for the store buffer to drain, runs the data-cache flush handshake when the operation needs one, and finishes by issuing the I$/TLB flush pulses and the pipeline flush to the controller. It sits between the commit stage, the LSU/store buffer, the caches and the controller.

## Interface
- `FLUSH_DCACHE_ON_FENCE`, default 1: 1 = FENCE also flushes the D$; 0 = FENCE only drains the store buffer.
- `LAT_W`, default 16: width of the latency counter.
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; synchronous, active-high. The reset polarity and synchronicity are fixed.
- `halt_i`  in  1  halt request; blocks acceptance of new requests.
- `req_valid_i`  in  1  fence request from commit.
- `req_type_i`  in  2  request type: 00 FENCE, 01 FENCE_I, 10 SFENCE_VMA, 11 DCACHE_FLUSH.
- `req_ready_o`  out  1  request is accepted in the same cycle when `req_valid_i & req_ready_o`.
- `no_st_pending_i`  in  1  store buffer is empty.
- `flush_dcache_o`  out  1  D$ flush request; level signal, held until acknowledged.
- `flush_dcache_ack_i`  in  1  D$ flush complete; single-cycle pulse.
- `flush_icache_o`  out  1  I$ flush; 1-cycle pulse.
- `flush_tlb_o`  out  1  TLB flush; 1-cycle pulse.
- `flush_pipeline_o`  out  1  pipeline flush to controller; 1-cycle pulse.
- `done_o`  out  1  operation complete; 1-cycle pulse. Commit acks the instruction on this pulse.
- `busy_o`  out  1  sequencer is not in IDLE.
- `lat_o`  out  LAT_W  cycles from accept to done for the last operation; saturating.

## Operation
- FSM states: IDLE, DRAIN, DFLUSH, FINISH.
- IDLE: `req_ready_o = !halt_i`.
  - On accept, the type is latched into `type_q`, the latency counter is cleared to 1, and the FSM moves to DRAIN.
- DRAIN: waits for `no_st_pending_i = 1`, sampled in the current cycle.
  - On drain, if `need_dflush` the FSM goes to DFLUSH; otherwise it goes to FINISH.
  - `need_dflush` = (type == FENCE_I) | (type == DCACHE_FLUSH) | (type == FENCE & FLUSH_DCACHE_ON_FENCE).
  - No timeout: the FSM waits indefinitely.
- DFLUSH: `flush_dcache_o = 1` for every cycle spent in this state.
  - On `flush_dcache_ack_i`, go to FINISH.
  - An ack received in any other state is ignored.
- FINISH: lasts exactly one cycle, then returns to IDLE. In this cycle:
  - `done_o = 1` and `flush_pipeline_o = 1`.
  - `flush_icache_o = 1` if type is FENCE_I or DCACHE_FLUSH.
  - `flush_tlb_o = 1` if type is SFENCE_VMA.
- `busy_o = (state != IDLE)`.
- Latency counter:
  - Increments in every non-IDLE cycle and saturates at 2^LAT_W-1.
  - `lat_o` is updated with the final count in the FINISH cycle, including the FINISH cycle itself. It holds that value until the next FINISH.
- `halt_i` asserted mid-operation has no effect; the operation completes.
- There is no request queueing: commit must hold `req_valid_i` until it sees ready.

## Timing
- Reset values: state IDLE, `type_q` = 00, counter = 0, `lat_o` = 0.
  - All pulse outputs, `flush_dcache_o` and `busy_o` are 0.
  - `req_ready_o` = `!halt_i`.
- Reset asserted mid-operation aborts at the next edge: state returns to IDLE and `flush_dcache_o` drops the following cycle. Any late `flush_dcache_ack_i` is then ignored.
- All outputs are Moore outputs, decoded from the registered state, except `req_ready_o`, which depends on `halt_i` combinationally.
- Minimum latency with drain and ack immediate, accept in cycle 0:
  - Without D$ flush: DRAIN in cycle 1, FINISH in cycle 2; `lat_o` = 2.
  - With D$ flush: DRAIN in cycle 1, DFLUSH in cycle 2 with ack in cycle 2, FINISH in cycle 3; `lat_o` = 3.
- Back-to-back operation: IDLE is re-entered in the cycle after FINISH, and a new accept is possible in that cycle. Throughput is therefore at most one operation per 3 cycles.
- `req_valid_i` while busy: not accepted, no state change.

## Test plan
- SFENCE_VMA accepted with `no_st_pending_i` = 1 → `flush_tlb_o`, `flush_pipeline_o` and `done_o` pulse in cycle 2; `flush_dcache_o` never asserts; `lat_o` = 2.
- FENCE_I with store buffer draining after 5 cycles and ack 4 cycles after DFLUSH entry:
  - `flush_dcache_o` is high for exactly 5 cycles.
  - `flush_icache_o` and `done_o` pulse once; `lat_o` = 11.
- FENCE with `FLUSH_DCACHE_ON_FENCE` = 0 → no `flush_dcache_o`, no I$/TLB pulse; `flush_pipeline_o` pulses once. Repeat with the parameter = 1: the D$ handshake occurs.
- `halt_i` = 1 with `req_valid_i` = 1 in IDLE → `req_ready_o` = 0 and no state change. `halt_i` rising during DFLUSH → the operation still completes with `done_o`.
- Reset during DFLUSH, followed by a stray ack → IDLE, all outputs at reset values, and the stray ack causes no transition. `lat_o` with `LAT_W` = 4 and a 20-cycle drain saturates at 15.
- Back-to-back DCACHE_FLUSH then SFENCE_VMA, with valid held → second request accepted in the cycle after the first FINISH; a new request during busy cycles is never accepted.

Source files
------------

// File: rtl/fence_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA / D$ flush operations from commit:
// drain the store buffer, optionally flush the D$, then pulse I$/TLB/pipeline flushes.
module fence_sequencer #(
    parameter bit          FLUSH_DCACHE_ON_FENCE = 1'b1,
    parameter int unsigned LAT_W                 = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             halt_i,
    input  logic             req_valid_i,
    input  logic [1:0]       req_type_i,
    output logic             req_ready_o,
    input  logic             no_st_pending_i,
    output logic             flush_dcache_o,
    input  logic             flush_dcache_ack_i,
    output logic             flush_icache_o,
    output logic             flush_tlb_o,
    output logic             flush_pipeline_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [LAT_W-1:0] lat_o
);

    typedef enum logic [1:0] {StIdle, StDrain, StDflush, StFinish} state_e;

    localparam logic [1:0] TypeFence       = 2'b00;
    localparam logic [1:0] TypeFenceI      = 2'b01;
    localparam logic [1:0] TypeSfenceVma   = 2'b10;
    localparam logic [1:0] TypeDcacheFlush = 2'b11;

    localparam logic [LAT_W-1:0] LatMax = {LAT_W{1'b1}};

    state_e           state_q, state_d;
    logic [1:0]       type_q, type_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             need_dflush;

    assign need_dflush = (type_q == TypeFenceI) | (type_q == TypeDcacheFlush) |
                         ((type_q == TypeFence) & FLUSH_DCACHE_ON_FENCE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            type_q  <= 2'b00;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        type_d           = type_q;
        cnt_d            = cnt_q;
        lat_d            = lat_q;
        req_ready_o      = 1'b0;
        flush_dcache_o   = 1'b0;
        flush_icache_o   = 1'b0;
        flush_tlb_o      = 1'b0;
        flush_pipeline_o = 1'b0;
        done_o           = 1'b0;

        // Counter runs through every busy cycle; the accept cycle itself seeds it with 1.
        if (state_q != StIdle) begin
            cnt_d = (cnt_q == LatMax) ? cnt_q : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                req_ready_o = !halt_i;
                if (req_valid_i && !halt_i) begin
                    type_d  = req_type_i;
                    cnt_d   = {{(LAT_W-1){1'b0}}, 1'b1};
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (no_st_pending_i) begin
                    state_d = need_dflush ? StDflush : StFinish;
                end
            end
            StDflush: begin
                flush_dcache_o = 1'b1;
                if (flush_dcache_ack_i) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                done_o           = 1'b1;
                flush_pipeline_o = 1'b1;
                flush_icache_o   = (type_q == TypeFenceI) | (type_q == TypeDcacheFlush);
                flush_tlb_o      = (type_q == TypeSfenceVma);
                lat_d            = cnt_q;
                state_d          = StIdle;
            end
        endcase
    end

    assign busy_o = (state_q != StIdle);
    assign lat_o  = lat_q;

endmodule

// File: tb/tb_fence_sequencer.sv
// Randomized + directed bench for fence_sequencer; three parameterizations share stimulus
// and are each checked every cycle against a cycle-stamp based reference model.
module tb_fence_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       halt;
    logic       req_valid;
    logic [1:0] req_type;
    logic       nsp;
    logic       ack;

    always #5 clk = ~clk;

    logic [6:0]  obs [3];
    logic [15:0] lat_obs [3];

    logic        rdy0, fd0, fi0, ft0, fp0, dn0, bsy0;
    logic        rdy1, fd1, fi1, ft1, fp1, dn1, bsy1;
    logic        rdy2, fd2, fi2, ft2, fp2, dn2, bsy2;
    logic [15:0] lat0, lat1;
    logic [3:0]  lat2;

    fence_sequencer #(.FLUSH_DCACHE_ON_FENCE(1'b1), .LAT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .halt_i(halt), .req_valid_i(req_valid),
        .req_type_i(req_type), .req_ready_o(rdy0), .no_st_pending_i(nsp),
        .flush_dcache_o(fd0), .flush_dcache_ack_i(ack), .flush_icache_o(fi0),
        .flush_tlb_o(ft0), .flush_pipeline_o(fp0), .done_o(dn0), .busy_o(bsy0), .lat_o(lat0)
    );

    fence_sequencer #(.FLUSH_DCACHE_ON_FENCE(1'b0), .LAT_W(16)) dut_nf (
        .clk_i(clk), .rst_i(rst), .halt_i(halt), .req_valid_i(req_valid),
        .req_type_i(req_type), .req_ready_o(rdy1), .no_st_pending_i(nsp),
        .flush_dcache_o(fd1), .flush_dcache_ack_i(ack), .flush_icache_o(fi1),
        .flush_tlb_o(ft1), .flush_pipeline_o(fp1), .done_o(dn1), .busy_o(bsy1), .lat_o(lat1)
    );

    fence_sequencer #(.FLUSH_DCACHE_ON_FENCE(1'b1), .LAT_W(4)) dut_l4 (
        .clk_i(clk), .rst_i(rst), .halt_i(halt), .req_valid_i(req_valid),
        .req_type_i(req_type), .req_ready_o(rdy2), .no_st_pending_i(nsp),
        .flush_dcache_o(fd2), .flush_dcache_ack_i(ack), .flush_icache_o(fi2),
        .flush_tlb_o(ft2), .flush_pipeline_o(fp2), .done_o(dn2), .busy_o(bsy2), .lat_o(lat2)
    );

    // Bit order: {ready, busy, flush_dcache, flush_icache, flush_tlb, flush_pipeline, done}
    assign obs[0] = {rdy0, bsy0, fd0, fi0, ft0, fp0, dn0};
    assign obs[1] = {rdy1, bsy1, fd1, fi1, ft1, fp1, dn1};
    assign obs[2] = {rdy2, bsy2, fd2, fi2, ft2, fp2, dn2};
    assign lat_obs[0] = lat0;
    assign lat_obs[1] = lat1;
    assign lat_obs[2] = {12'b0, lat2};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: phase 0 idle, 1 waiting for drain, 2 waiting for D$ ack, 3 finishing.
    int         m_phase [3];
    logic [1:0] m_type  [3];
    int         m_start [3];
    int         m_lat   [3];
    int         lat_max [3] = '{65535, 65535, 15};
    bit         fof     [3] = '{1'b1, 1'b0, 1'b1};

    int fd_cnt [3];
    int fi_cnt [3];
    int ft_cnt [3];
    int dn_cnt [3];
    int acc_cyc [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            fd_cnt[i] = 0; fi_cnt[i] = 0; ft_cnt[i] = 0; dn_cnt[i] = 0;
        end
        acc_cyc.delete();
    endtask

    function automatic logic [6:0] expect_outs(input int i);
        logic fin;
        fin = (m_phase[i] == 3);
        return {(m_phase[i] == 0) && !halt, m_phase[i] != 0, m_phase[i] == 2,
                fin && (m_type[i] == 2'd1 || m_type[i] == 2'd3), fin && (m_type[i] == 2'd2),
                fin, fin};
    endfunction

    function automatic bit needs_dflush(input int i, input logic [1:0] t);
        return (t == 2'd1) || (t == 2'd3) || (t == 2'd0 && fof[i]);
    endfunction

    // Check at negedge, advance the model, then return 1 time unit after the next posedge.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("outs%0d", i), 32'(obs[i]), 32'(expect_outs(i)));
            check_eq($sformatf("lat%0d", i), 32'(lat_obs[i]), 32'(m_lat[i]));
            if (obs[i][4]) fd_cnt[i]++;
            if (obs[i][3]) fi_cnt[i]++;
            if (obs[i][2]) ft_cnt[i]++;
            if (obs[i][0]) dn_cnt[i]++;
            if (i == 0 && obs[0][6] && req_valid) acc_cyc.push_back(cyc);
            if (rst) begin
                m_phase[i] = 0; m_type[i] = 2'd0; m_lat[i] = 0;
            end else begin
                case (m_phase[i])
                    0: if (req_valid && !halt) begin
                        m_type[i] = req_type; m_start[i] = cyc; m_phase[i] = 1;
                    end
                    1: if (nsp) m_phase[i] = needs_dflush(i, m_type[i]) ? 2 : 3;
                    2: if (ack) m_phase[i] = 3;
                    default: begin
                        m_lat[i]   = (cyc - m_start[i] > lat_max[i]) ? lat_max[i]
                                                                      : cyc - m_start[i];
                        m_phase[i] = 0;
                    end
                endcase
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic n, input logic a,
                         input logic h, input logic r);
        req_valid = v; req_type = t; nsp = n; ack = a; halt = h; rst = r;
    endtask

    initial begin
        int idx;
        logic [1:0] b2b [2];
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            m_phase[i] = 0; m_type[i] = 2'd0; m_start[i] = 0; m_lat[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // SFENCE.VMA with empty store buffer
        clear_counts();
        drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        check_eq("sfence_lat", 32'(lat0), 32'd2);
        check_eq("sfence_tlb", fd_cnt[0] * 16 + ft_cnt[0], 32'd1);

        // FENCE.I: drain after 5 cycles, ack 4 cycles into DFLUSH
        clear_counts();
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        nsp = 1'b1;
        tick();
        nsp = 1'b0;
        repeat (4) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (2) tick();
        check_eq("fencei_lat", 32'(lat0), 32'd11);
        check_eq("fencei_dflush_cycles", fd_cnt[0], 32'd5);
        check_eq("fencei_icache_pulses", fi_cnt[0], 32'd1);
        check_eq("fencei_done_pulses", dn_cnt[0], 32'd1);

        // FENCE with and without D$ flush
        clear_counts();
        drive(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        ack = 1'b0;
        check_eq("fence_nf_dflush", fd_cnt[1], 32'd0);
        check_eq("fence_nf_ic_tlb", fi_cnt[1] + ft_cnt[1], 32'd0);
        check_eq("fence_nf_done", dn_cnt[1], 32'd1);
        check_eq("fence_f_dflush", fd_cnt[0], 32'd1);
        check_eq("fence_f_lat", 32'(lat0), 32'd3);

        // Halt blocks acceptance in IDLE; halt during DFLUSH does not stop the operation
        clear_counts();
        drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        check_eq("halt_ready", 32'(rdy0), 32'd0);
        check_eq("halt_busy", 32'(bsy0), 32'd0);
        halt = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        halt = 1'b1;
        repeat (2) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (2) tick();
        halt = 1'b0;
        check_eq("halt_mid_done", dn_cnt[0], 32'd1);

        // Reset during DFLUSH followed by a stray ack
        clear_counts();
        drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (2) tick();
        check_eq("rst_busy", 32'(bsy0), 32'd0);
        check_eq("rst_dflush", 32'(fd0), 32'd0);
        check_eq("rst_lat", 32'(lat0), 32'd0);
        check_eq("rst_done", dn_cnt[0], 32'd0);

        // 20-cycle drain: saturates at 15 with LAT_W = 4
        clear_counts();
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        repeat (19) tick();
        nsp = 1'b1;
        tick();
        nsp = 1'b0;
        repeat (2) tick();
        check_eq("sat_lat4", 32'(lat2), 32'd15);
        check_eq("sat_lat16", 32'(lat0), 32'd21);

        // Back-to-back DCACHE_FLUSH then SFENCE.VMA with valid held
        clear_counts();
        b2b[0] = 2'd3;
        b2b[1] = 2'd2;
        idx = 0;
        drive(1'b1, b2b[0], 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            req_valid = (idx < 2);
            req_type  = (idx < 2) ? b2b[idx] : 2'd0;
            tick();
            idx = acc_cyc.size();
        end
        ack = 1'b0;
        check_eq("b2b_accepts", acc_cyc.size(), 32'd2);
        if (acc_cyc.size() == 2) check_eq("b2b_gap", acc_cyc[1] - acc_cyc[0], 32'd4);
        check_eq("b2b_done", dn_cnt[0], 32'd2);
        check_eq("b2b_tlb", ft_cnt[0], 32'd1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(1, 0) == 1, 2'($urandom_range(3, 0)),
                  $urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0,
                  $urandom_range(3, 0) == 0, $urandom_range(63, 0) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
